// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational instruction ROM, issue
// counter and global branch history. Fetch stops after any control-flow
// instruction and resumes only when AGEX redirects the PC.
// The ROM contents come in through the IMEM_IMAGE parameter, which keeps the
// block free of file loading. IMEM_INIT names the hex image for flows that
// build IMEM_IMAGE from that file.
module fetch_stage #(
  parameter int               DBITS      = 32,
  parameter int               INSTBITS   = 32,
  parameter int               IMEM_WORDS = 16384,
  parameter string            IMEM_INIT  = "imem.hex",
  parameter logic [DBITS-1:0] START_PC   = '0,
  parameter int               BHR_BITS   = 8,
  parameter logic [3:0]       CANARY     = 4'hF,
  parameter logic [INSTBITS-1:0] IMEM_IMAGE [IMEM_WORDS] = '{default: '0}
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   de_stall,
  input  logic                                   br_redirect,
  input  logic [DBITS-1:0]                       br_target,
  input  logic                                   br_resolve,
  input  logic                                   br_taken,
  output logic                                   fe_busy,
  output logic [INSTBITS+3*DBITS+BHR_BITS+3:0]   FE_latch_out
);

  localparam int AW = $clog2(IMEM_WORDS);

  typedef struct packed {
    logic [INSTBITS-1:0] inst;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pcplus;
    logic [DBITS-1:0]    count;
    logic [BHR_BITS-1:0] bhr;
    logic [3:0]          canary;
  } fe_latch_t;

  typedef enum logic {RUN = 1'b0, WAIT_BR = 1'b1} state_t;

  state_t              state;
  fe_latch_t           latch;
  logic [DBITS-1:0]    pc;
  logic [DBITS-1:0]    pcplus;
  logic [DBITS-1:0]    inst_count;
  logic [BHR_BITS-1:0] bhr;
  logic [INSTBITS-1:0] inst;
  logic [DBITS-1:0]    target;
  logic                is_cf;
  logic                unused_target_lsbs;
  logic                unused_init_name;

  // ROM read: only the word-index bits of the PC address the array, so the
  // upper bits alias (wrap) onto the same image.
  assign inst   = IMEM_IMAGE[pc[AW+1:2]];
  assign pcplus = pc + DBITS'(4);

  // Redirect targets are forced to word alignment.
  assign target             = {br_target[DBITS-1:2], 2'b00};
  assign unused_target_lsbs = ^br_target[1:0];
  assign unused_init_name   = (IMEM_INIT.len() == 0);

  // Branch, JAL and JALR all stop fetch until AGEX resolves them.
  assign is_cf = (inst[6:0] == 7'b1100011) ||
                 (inst[6:0] == 7'b1101111) ||
                 (inst[6:0] == 7'b1100111);

  assign FE_latch_out = latch;

  // Fetch FSM, PC, issue counter and FE latch; BHR shifts on every resolve
  // regardless of state or stall, and a same-cycle latch load sees the old BHR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      fe_busy    <= 1'b0;
      pc         <= START_PC;
      latch      <= '0;
      inst_count <= '0;
      bhr        <= '0;
    end else begin
      if (br_resolve) bhr <= {bhr[BHR_BITS-2:0], br_taken};
      case (state)
        RUN: begin
          if (br_redirect) begin
            // Spurious redirect: squash the latch even if DE is stalled.
            pc    <= target;
            latch <= '0;
          end else if (!de_stall) begin
            latch      <= '{inst: inst, pc: pc, pcplus: pcplus,
                            count: inst_count, bhr: bhr, canary: CANARY};
            pc         <= pcplus;
            inst_count <= inst_count + DBITS'(1);
            if (is_cf) begin
              state   <= WAIT_BR;
              fe_busy <= 1'b1;
            end
          end
        end
        WAIT_BR: begin
          if (!de_stall) latch <= '0;
          if (br_redirect) begin
            pc      <= target;
            state   <= RUN;
            fe_busy <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          fe_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall hold,
// branch wait/redirect, BHR update timing, PC wrap and async reset in WAIT_BR.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'h0010_0093;
  localparam logic [31:0] A1  = 32'h0020_0113;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] JAL = 32'h0000_006F;
  localparam logic [31:0] A16 = 32'h0400_0193;
  localparam logic [31:0] A63 = 32'h7FF0_0213;
  localparam logic [31:0] IMG [64] = '{0: A0, 1: A1, 4: BEQ, 6: JAL,
                                       16: A16, 63: A63, default: NOP};

  logic         clk = 1'b0;
  logic         reset;
  logic         de_stall;
  logic         br_redirect;
  logic [31:0]  br_target;
  logic         br_resolve;
  logic         br_taken;
  logic         fe_busy;
  logic [139:0] FE_latch_out;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_stage #(.IMEM_WORDS(64), .IMEM_INIT(""), .IMEM_IMAGE(IMG)) dut (
    .clk(clk), .reset(reset), .de_stall(de_stall), .br_redirect(br_redirect),
    .br_target(br_target), .br_resolve(br_resolve), .br_taken(br_taken),
    .fe_busy(fe_busy), .FE_latch_out(FE_latch_out)
  );

  always #5 clk = ~clk;

  function automatic logic [139:0] lat(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] cnt, input logic [7:0] bhr);
    logic [31:0] pcp;
    pcp = pc + 32'd4;
    return {inst, pc, pcp, cnt, bhr, 4'hF};
  endfunction

  task automatic chk(input string tag, input logic [139:0] got, input logic [139:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; de_stall = 1'b0; br_redirect = 1'b0; br_target = '0;
    br_resolve = 1'b0; br_taken = 1'b0;
    repeat (3) step();
    chk("rst_latch", FE_latch_out, '0);
    chk("rst_busy", 140'(fe_busy), 140'(0));
    reset = 1'b1;
    #2;
    chk("rel_latch", FE_latch_out, '0);

    // sequential fetch with a two-cycle stall at pc=8
    step(); chk("pc0", FE_latch_out, lat(A0, 32'h0, 0, 8'h00));
    step(); chk("pc4", FE_latch_out, lat(A1, 32'h4, 1, 8'h00));
    step(); chk("pc8", FE_latch_out, lat(NOP, 32'h8, 2, 8'h00));
    de_stall = 1'b1;
    step(); chk("stall1", FE_latch_out, lat(NOP, 32'h8, 2, 8'h00));
    step(); chk("stall2", FE_latch_out, lat(NOP, 32'h8, 2, 8'h00));
    de_stall = 1'b0;
    step(); chk("pcC", FE_latch_out, lat(NOP, 32'hC, 3, 8'h00));

    // BEQ enters WAIT_BR; stall holds the BEQ entry, then bubbles
    step(); chk("beq", FE_latch_out, lat(BEQ, 32'h10, 4, 8'h00));
    chk("beq_busy", 140'(fe_busy), 140'(1));
    de_stall = 1'b1;
    step(); chk("wait_stall", FE_latch_out, lat(BEQ, 32'h10, 4, 8'h00));
    de_stall = 1'b0;
    step(); chk("bubble1", FE_latch_out, '0);
    step(); chk("bubble2", FE_latch_out, '0);
    chk("still_busy", 140'(fe_busy), 140'(1));
    br_redirect = 1'b1; br_target = 32'h43;
    step(); chk("redir_bub", FE_latch_out, '0);
    chk("redir_busy", 140'(fe_busy), 140'(0));
    br_redirect = 1'b0;
    step(); chk("pc40", FE_latch_out, lat(A16, 32'h40, 5, 8'h00));

    // BHR: T,T while stalled, then N with a load carrying the old BHR
    br_resolve = 1'b1; br_taken = 1'b1; de_stall = 1'b1;
    step(); step();
    br_taken = 1'b0; de_stall = 1'b0;
    step(); chk("bhr_pre", FE_latch_out, lat(NOP, 32'h44, 6, 8'b0000_0011));
    br_resolve = 1'b0;
    step(); chk("bhr_post", FE_latch_out, lat(NOP, 32'h48, 7, 8'b0000_0110));

    // spurious redirect in RUN beats stall; target holds a JAL
    br_redirect = 1'b1; br_target = 32'h18; de_stall = 1'b1;
    step(); chk("spur_bub", FE_latch_out, '0);
    chk("spur_busy", 140'(fe_busy), 140'(0));
    br_redirect = 1'b0; de_stall = 1'b0;
    step(); chk("jal", FE_latch_out, lat(JAL, 32'h18, 8, 8'h06));
    chk("jal_busy", 140'(fe_busy), 140'(1));
    step(); chk("jal_bub", FE_latch_out, '0);

    // redirect near top of address space, unaligned target, under stall
    br_redirect = 1'b1; br_target = 32'hFFFF_FFFE; de_stall = 1'b1;
    step(); chk("top_hold", FE_latch_out, '0);
    chk("top_busy", 140'(fe_busy), 140'(0));
    br_redirect = 1'b0; de_stall = 1'b0;
    step(); chk("pc_top", FE_latch_out, lat(A63, 32'hFFFF_FFFC, 9, 8'h06));
    step(); chk("pc_wrap", FE_latch_out, lat(A0, 32'h0, 10, 8'h06));

    // reach BEQ again, then async reset while waiting
    repeat (4) step();
    chk("beq2", FE_latch_out, lat(BEQ, 32'h10, 14, 8'h06));
    #2 reset = 1'b0;
    #1;
    chk("async_latch", FE_latch_out, '0);
    chk("async_busy", 140'(fe_busy), 140'(0));
    #1 reset = 1'b1;
    step(); chk("post_rst", FE_latch_out, lat(A0, 32'h0, 0, 8'h00));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
